skein_word_sequencer: RTL and testbench

Upstream producer of the Skein message-word path. Accepts 64-bit message words, one or two per beat, over a valid/ready handshake. Drives the reset / +1 / +2 strobes of the shared 4-bit word counter and uses the counter's registered value as the write index into a 16-word (1024-bit) block buffer. Presents each completed or final block to the hash core over a second valid/ready handshake.

---
 rtl/skein_pkg.sv | 22 ++
 rtl/skein_block_buffer.sv | 34 +++
 rtl/skein_word_sequencer.sv | 148 ++++++++++++++
 tb/tb_skein_word_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/skein_pkg.sv
// Shared definitions for the Skein message-word path: sizes, sequencer
// state encoding and word-counter strobe selection.
package skein_pkg;

  localparam int SKEIN_WORD_W      = 64;
  localparam int SKEIN_BLOCK_WORDS = 16;
  localparam int SKEIN_CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_CLR  = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    STB_NONE = 2'd0,
    STB_RST  = 2'd1,
    STB_P1   = 2'd2,
    STB_P2   = 2'd3
  } strobe_sel_e;

endpackage

// File: rtl/skein_block_buffer.sv
// 16 x 64-bit block register file: two indexed write ports, synchronous
// clear, async reset to zero. Port 0 wins nothing; callers never alias indices.
module skein_block_buffer #(
  parameter int WORD_W = 64,
  parameter int WORDS  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       clr_i,
  input  logic                       we0_i,
  input  logic [$clog2(WORDS)-1:0]   idx0_i,
  input  logic [WORD_W-1:0]          data0_i,
  input  logic                       we1_i,
  input  logic [$clog2(WORDS)-1:0]   idx1_i,
  input  logic [WORD_W-1:0]          data1_i,
  output logic [WORDS*WORD_W-1:0]    data_o
);

  logic [WORDS-1:0][WORD_W-1:0] mem_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q <= '0;
    end else if (clr_i) begin
      mem_q <= '0;
    end else begin
      if (we0_i) mem_q[idx0_i] <= data0_i;
      if (we1_i) mem_q[idx1_i] <= data1_i;
    end
  end

  assign data_o = mem_q;

endmodule

// File: rtl/skein_word_sequencer.sv
// Skein message-word sequencer: packs 1- or 2-word beats into 16-word blocks
// using the shared word counter as write index. Pair beats need SKEIN_SEQ_PAIR_EN.
//
// state | meaning
// CLR   | one cycle after reset, clears the external word counter
// FILL  | accepting beats into the block buffer
// HOLD  | block presented to the hash core, waiting for block_ready_i
module skein_word_sequencer
  import skein_pkg::*;
#(
  parameter int WORD_W = SKEIN_WORD_W,
  parameter int WORDS  = SKEIN_BLOCK_WORDS
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     in_pair_i,
  input  logic [2*WORD_W-1:0]      in_data_i,
  input  logic                     in_last_i,
  input  logic [3:0]               word_counter_i,
  output logic                     word_counter_reset_o,
  output logic                     word_counter_plus_1_o,
  output logic                     word_counter_plus_2_o,
  output logic                     block_valid_o,
  input  logic                     block_ready_i,
  output logic [WORDS*WORD_W-1:0]  block_data_o,
  output logic [4:0]               block_words_o,
  output logic                     block_final_o,
  output logic                     overflow_o
);

  seq_state_e  state_q, state_d;
  strobe_sel_e strobe_sel;

  logic              pair_req;
  logic [WORD_W-1:0] hi_word;
  logic              at_last_idx;
  logic              pair_eff;
  logic [4:0]        fill_sum;
  logic              block_done;
  logic              accept;
  logic              handoff;

  logic [4:0] words_q, words_d;
  logic       final_q, final_d;
  logic       overflow_q, overflow_d;

`ifdef SKEIN_SEQ_PAIR_EN
  assign pair_req = in_pair_i;
  assign hi_word  = in_data_i[2*WORD_W-1:WORD_W];
`else
  logic unused_pair;
  assign unused_pair = ^{in_pair_i, in_data_i[2*WORD_W-1:WORD_W]};
  assign pair_req    = 1'b0;
  assign hi_word     = '0;
`endif

  // A pair at the last index keeps only its lower word and counts as one.
  assign at_last_idx = (word_counter_i == 4'(WORDS - 1));
  assign pair_eff    = pair_req & ~at_last_idx;
  assign fill_sum    = {1'b0, word_counter_i} + (pair_eff ? 5'd2 : 5'd1);
  assign block_done  = fill_sum[4] | in_last_i;
  assign accept      = in_valid_i & in_ready_o;
  assign handoff     = (state_q == ST_HOLD) & block_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_CLR;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLR:  state_d = ST_FILL;
      ST_FILL: if (accept && block_done) state_d = ST_HOLD;
      ST_HOLD: if (block_ready_i) state_d = ST_FILL;
      default: state_d = ST_CLR;
    endcase
  end

  always_comb begin
    in_ready_o = 1'b0;
    strobe_sel = STB_NONE;
    unique case (state_q)
      ST_CLR:  strobe_sel = STB_RST;
      ST_FILL: begin
        in_ready_o = 1'b1;
        if (in_valid_i) strobe_sel = pair_eff ? STB_P2 : STB_P1;
      end
      ST_HOLD: if (block_ready_i) strobe_sel = STB_RST;
      default: strobe_sel = STB_NONE;
    endcase
  end

  // The state register sits in CLR throughout reset; gating keeps the strobe low until release.
  assign word_counter_reset_o  = rst_n_i & (strobe_sel == STB_RST);
  assign word_counter_plus_1_o = (strobe_sel == STB_P1);
`ifdef SKEIN_SEQ_PAIR_EN
  assign word_counter_plus_2_o = (strobe_sel == STB_P2);
`else
  assign word_counter_plus_2_o = 1'b0;
`endif
  assign block_valid_o = (state_q == ST_HOLD);

  always_comb begin
    words_d    = words_q;
    final_d    = final_q;
    overflow_d = overflow_q | (accept & pair_req & at_last_idx);
    if (accept && block_done) begin
      words_d = fill_sum;
      final_d = in_last_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      words_q    <= '0;
      final_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      words_q    <= words_d;
      final_q    <= final_d;
      overflow_q <= overflow_d;
    end
  end

  assign block_words_o = words_q;
  assign block_final_o = final_q;
  assign overflow_o    = overflow_q;

  skein_block_buffer #(
    .WORD_W (WORD_W),
    .WORDS  (WORDS)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (handoff),
    .we0_i   (accept),
    .idx0_i  (word_counter_i),
    .data0_i (in_data_i[WORD_W-1:0]),
    .we1_i   (accept & pair_eff),
    .idx1_i  (word_counter_i + 4'd1),
    .data1_i (hi_word),
    .data_o  (block_data_o)
  );

endmodule

// File: tb/tb_skein_word_sequencer.sv
// Self-checking bench for skein_word_sequencer; models the external word
// counter and predicts blocks from a word-list reference model.
module tb_skein_word_sequencer;

`ifdef SKEIN_SEQ_PAIR_EN
  localparam bit PAIR = 1'b1;
`else
  localparam bit PAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_pair, in_last;
  logic [127:0]  in_data;
  logic [3:0]    cnt = 4'hA;
  logic          cnt_rst, p1, p2;
  logic          blk_valid, blk_ready;
  logic [1023:0] blk_data;
  logic [4:0]    blk_words;
  logic          blk_final, ovf;

  int checks = 0;
  int errors = 0;

  logic [63:0]   m_words[$];
  bit            m_ovf = 1'b0;
  bit            m_blk_rdy = 1'b0;
  logic [1023:0] m_blk_data;
  int            m_blk_words;
  bit            m_blk_final;

  always #5 clk = ~clk;

  // External 4-bit word counter driven by the sequencer's strobes.
  always @(posedge clk) begin
    if (cnt_rst)  cnt <= 4'd0;
    else if (p1)  cnt <= cnt + 4'd1;
    else if (p2)  cnt <= cnt + 4'd2;
  end

  skein_word_sequencer dut (
    .clk_i                 (clk),
    .rst_n_i               (rst_n),
    .in_valid_i            (in_valid),
    .in_ready_o            (in_ready),
    .in_pair_i             (in_pair),
    .in_data_i             (in_data),
    .in_last_i             (in_last),
    .word_counter_i        (cnt),
    .word_counter_reset_o  (cnt_rst),
    .word_counter_plus_1_o (p1),
    .word_counter_plus_2_o (p2),
    .block_valid_o         (blk_valid),
    .block_ready_i         (blk_ready),
    .block_data_o          (blk_data),
    .block_words_o         (blk_words),
    .block_final_o         (blk_final),
    .overflow_o            (ovf)
  );

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic beat(input bit pair, input logic [63:0] lo, input logic [63:0] hi, input bit last);
    int t;
    bit two;
    t = 0;
    while (in_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t == 40) begin
      errors++;
      $display("FAIL beat_ready_timeout got %b exp 1", in_ready);
    end
    in_valid = 1'b1;
    in_pair  = pair;
    in_data  = {hi, lo};
    in_last  = last;
    two = PAIR && pair && (m_words.size() < 15);
    #1;
    checks++;
    if ({cnt_rst, p1, p2} !== {1'b0, !two, two}) begin
      errors++;
      $display("FAIL beat_strobes got %b exp %b", {cnt_rst, p1, p2}, {1'b0, !two, two});
    end
    if (PAIR && pair && m_words.size() == 15) m_ovf = 1'b1;
    m_words.push_back(lo);
    if (two) m_words.push_back(hi);
    if (m_words.size() == 16 || last) begin
      m_blk_data = '0;
      foreach (m_words[k]) m_blk_data[k*64 +: 64] = m_words[k];
      m_blk_words = m_words.size();
      m_blk_final = last;
      m_blk_rdy   = 1'b1;
      m_words.delete();
    end
    @(negedge clk);
  endtask

  task automatic expect_block(input int hold);
    in_valid = (hold > 0);
    in_data  = {rnd64(), rnd64()};
    checks++;
    if (!m_blk_rdy) begin
      errors++;
      $display("FAIL block_model_not_ready got 0 exp 1");
    end
    checks++;
    if ({blk_valid, in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL block_valid_ready got %b exp 10", {blk_valid, in_ready});
    end
    checks++;
    if (blk_data !== m_blk_data) begin
      errors++;
      for (int k = 0; k < 16; k++)
        if (blk_data[k*64 +: 64] !== m_blk_data[k*64 +: 64])
          $display("FAIL block_data word %0d got %h exp %h", k, blk_data[k*64 +: 64], m_blk_data[k*64 +: 64]);
    end
    checks++;
    if (blk_words !== 5'(m_blk_words)) begin
      errors++;
      $display("FAIL block_words got %0d exp %0d", blk_words, m_blk_words);
    end
    checks++;
    if (blk_final !== m_blk_final) begin
      errors++;
      $display("FAIL block_final got %b exp %b", blk_final, m_blk_final);
    end
    checks++;
    if (ovf !== m_ovf) begin
      errors++;
      $display("FAIL overflow got %b exp %b", ovf, m_ovf);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if ({blk_valid, in_ready, cnt_rst, p1, p2, blk_words, blk_final} !==
          {1'b1, 1'b0, 3'b000, 5'(m_blk_words), m_blk_final} || blk_data !== m_blk_data) begin
        errors++;
        $display("FAIL hold_stable cycle %0d got v%b r%b s%b w%0d f%b deq%b exp v1 r0 s000 w%0d f%b deq1",
                 i, blk_valid, in_ready, {cnt_rst, p1, p2}, blk_words, blk_final,
                 blk_data === m_blk_data, m_blk_words, m_blk_final);
      end
    end
    in_valid  = 1'b0;
    blk_ready = 1'b1;
    #1;
    checks++;
    if ({cnt_rst, p1, p2} !== 3'b100) begin
      errors++;
      $display("FAIL handoff_strobe got %b exp 100", {cnt_rst, p1, p2});
    end
    @(negedge clk);
    blk_ready = 1'b0;
    checks++;
    if ({blk_valid, in_ready, cnt} !== {1'b0, 1'b1, 4'd0} || blk_data !== '0) begin
      errors++;
      $display("FAIL after_handoff got v%b r%b cnt%0d data_zero%b exp v0 r1 cnt0 data_zero1",
               blk_valid, in_ready, cnt, blk_data === '0);
    end
    m_blk_rdy = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({in_ready, cnt_rst, p1, p2, blk_valid, blk_words, blk_final, ovf} !== '0 || blk_data !== '0) begin
      errors++;
      $display("FAIL %s got r%b s%b v%b w%0d f%b o%b data_zero%b exp all zero", tag, in_ready,
               {cnt_rst, p1, p2}, blk_valid, blk_words, blk_final, ovf, blk_data === '0);
    end
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({cnt_rst, in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL clr_cycle got rst%b ready%b exp rst1 ready0", cnt_rst, in_ready);
    end
    @(negedge clk);
    checks++;
    if ({cnt_rst, in_ready, cnt} !== {1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL fill_entry got rst%b ready%b cnt%0d exp rst0 ready1 cnt0", cnt_rst, in_ready, cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_pair = 1'b0; in_last = 1'b0;
    in_data = '0; blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    release_reset();
  endtask

  task automatic test_single16();
    for (int k = 0; k < 16; k++) beat(1'b0, 64'(k), rnd64(), 1'b0);
    expect_block(0);
  endtask

  task automatic test_pairs();
    int guard;
    guard = 0;
    while (!m_blk_rdy && guard < 32) begin
      beat(1'b1, 64'(m_words.size()), 64'(m_words.size() + 1), 1'b0);
      guard++;
    end
    expect_block(5);
  endtask

  task automatic test_last3();
    beat(1'b0, rnd64(), rnd64(), 1'b0);
    beat(1'b0, rnd64(), rnd64(), 1'b0);
    beat(1'b0, rnd64(), rnd64(), 1'b1);
    expect_block(1);
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 15; k++) beat(1'b0, rnd64(), rnd64(), 1'b0);
    beat(1'b1, rnd64(), rnd64(), 1'b1);
    expect_block(0);
  endtask

  task automatic test_random();
    for (int m = 0; m < 12; m++) begin
      int nb;
      nb = 1 + int'($urandom_range(19));
      for (int j = 0; j < nb; j++) begin
        beat(1'($urandom_range(1)), rnd64(), rnd64(), j == nb - 1);
        if (m_blk_rdy) expect_block(int'($urandom_range(3)));
        else if ($urandom_range(3) == 0) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic test_midreset();
    for (int k = 0; k < 5; k++) beat(1'($urandom_range(1)), rnd64(), rnd64(), 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset_outputs");
    m_words.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    release_reset();
    beat(1'b0, rnd64(), rnd64(), 1'b0);
    beat(1'b0, rnd64(), rnd64(), 1'b1);
    expect_block(0);
  endtask

  initial begin
    test_reset();
    test_single16();
    test_pairs();
    test_last3();
    test_overflow();
    test_random();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
